// File: rtl/nr_divider_seq.sv
// Sequential unsigned non-restoring divider.
// One quotient bit per cycle from a single controlled add/subtract. A
// correction step fixes a negative final remainder. A one-cycle done pulse
// marks the results as valid. A zero divisor skips the iteration and reports
// all-ones quotient, the dividend as remainder, and a flag.
module nr_divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_r;     // two's-complement partial remainder
  logic [WIDTH:0]   r_d;     // latched divisor, zero-extended
  logic [WIDTH-1:0] r_q;     // dividend shifting out, quotient shifting in
  logic             r_zero;  // current operation took the divide-by-zero path

  logic             w_ctrl;
  logic [WIDTH:0]   w_shift_r;
  logic [WIDTH:0]   w_operand;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_fix;

  // Controlled add/subtract. A non-negative remainder subtracts D, a negative
  // one adds D. Subtraction inverts D and injects the control bit as carry-in.
  // The shifted remainder may wrap, but the result always lies in [-D, D) and
  // fits in WIDTH+1 bits, so the modular sum is exact.
  assign w_ctrl    = ~r_r[WIDTH];
  assign w_shift_r = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_operand = r_d ^ {(WIDTH + 1){w_ctrl}};
  assign w_sum     = w_shift_r + w_operand + {{WIDTH{1'b0}}, w_ctrl};
  assign w_fix     = r_r + r_d;

  // Control FSM, datapath registers and registered outputs.
  // NOTE: every register here, including the datapath, gets a known reset
  // value. Nonblocking assignments keep all updates on the same edge
  // independent of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_r             <= '0;
      r_d             <= '0;
      r_q             <= '0;
      r_zero          <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      quotient_out    <= '0;
      remainder_out   <= '0;
      div_by_zero_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      busy_out <= (r_state != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_q             <= dividend_in;
            r_d             <= {1'b0, divisor_in};
            r_r             <= '0;
            r_cnt           <= '0;
            r_zero          <= (divisor_in == '0);
            div_by_zero_out <= 1'b0;
            r_state         <= (divisor_in == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_r   <= w_sum;
          r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_r[WIDTH]) begin
            r_r <= w_fix;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          done_out        <= 1'b1;
          quotient_out    <= r_zero ? '1 : r_q;
          remainder_out   <= r_zero ? r_q : r_r[WIDTH-1:0];
          div_by_zero_out <= r_zero;
          r_state         <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_divider_seq.sv
// Scoreboard bench for nr_divider_seq (WIDTH=8). The driver pushes the
// expected result of each accepted division. A negedge monitor pops and
// compares on every done pulse: results, latency and busy duration.
module tb_nr_divider_seq;

  localparam int WIDTH = 8;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int acc;
    int lat;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] quotient_out;
  logic [WIDTH-1:0] remainder_out;
  logic             div_by_zero_out;

  exp_t sb[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   busy_run = 0;

  nr_divider_seq #(.WIDTH(WIDTH)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .dividend_in     (dividend),
    .divisor_in      (divisor),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .quotient_out    (quotient_out),
    .remainder_out   (remainder_out),
    .div_by_zero_out (div_by_zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: tracks the busy run length and scores every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy_out) busy_run++;
      else busy_run = 0;
      if (done_out) begin
        if (sb.size() == 0) begin
          check("unexpected_done", int'(done_out), 0);
        end else begin
          e_mon = sb.pop_front();
          check("quotient", int'(quotient_out), e_mon.q);
          check("remainder", int'(remainder_out), e_mon.r);
          check("div_by_zero", int'(div_by_zero_out), e_mon.dbz);
          check("latency", cyc - e_mon.acc, e_mon.lat);
          check("busy_cycles", busy_run, e_mon.lat);
          if (e_mon.dbz == 0)
            check("q*d+r", int'(quotient_out) * e_mon.b + int'(remainder_out), e_mon.a);
        end
      end
    end
  end

  // Called at a negedge: raises start for one edge, returns at the next negedge.
  task automatic start_op(input int a, input int b, input int q, input int r,
                          input int dbz, input bit push);
    exp_t e;
    start    = 1'b1;
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    @(negedge clk);
    start = 1'b0;
    if (push) begin
      e.a   = a;
      e.b   = b;
      e.q   = q;
      e.r   = r;
      e.dbz = dbz;
      e.acc = cyc;
      e.lat = (b == 0) ? 1 : WIDTH + 2;
      sb.push_back(e);
    end
  endtask

  // Returns at the negedge on which done_out is seen (the done cycle).
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_out) seen = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", int'(seen), 1);
  endtask

  task automatic div_op(input int a, input int b, input int q, input int r, input int dbz);
    start_op(a, b, q, r, dbz, 1'b1);
    @(negedge clk);
    wait_done();
  endtask

  initial begin
    int a;
    int b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy_out), 0);
    check("rst_done", int'(done_out), 0);
    check("rst_quot", int'(quotient_out), 0);
    check("rst_rem", int'(remainder_out), 0);
    check("rst_dbz", int'(div_by_zero_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic and boundary operands; each new start issued in the previous done cycle.
    div_op(100, 7, 14, 2, 0);
    div_op(255, 1, 255, 0, 0);
    div_op(5, 9, 0, 5, 0);
    div_op(0, 13, 0, 0, 0);
    div_op(255, 255, 1, 0, 0);
    div_op(254, 255, 0, 254, 0);
    div_op(128, 3, 42, 2, 0);
    div_op(1, 255, 0, 1, 0);

    // Divide by zero, then a normal division clears the flag.
    div_op(200, 0, 255, 200, 1);
    div_op(9, 3, 3, 0, 0);
    div_op(0, 0, 255, 0, 1);

    // Start while busy is ignored; a start in the done cycle is accepted.
    start_op(100, 7, 14, 2, 0, 1'b1);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'd3;
    divisor  = 8'd0;
    wait_done();
    div_op(50, 5, 10, 0, 0);
    @(negedge clk);
    @(negedge clk);

    // Asynchronous reset mid-operation aborts with outputs cleared at once.
    start_op(100, 7, 0, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", int'(busy_out), 0);
    check("abort_done", int'(done_out), 0);
    check("abort_quot", int'(quotient_out), 0);
    check("abort_rem", int'(remainder_out), 0);
    check("abort_dbz", int'(div_by_zero_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", int'(done_out), 0);
    div_op(17, 4, 4, 1, 0);

    // Random cross-check against integer division.
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      if (b == 0) div_op(a, b, 255, a, 1);
      else        div_op(a, b, a / b, a % b, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
